// File: rtl/dlt_sweep_ctrl.sv
// dlt_sweep_ctrl: drives the shared D/G nets of the 32-latch CC_DLT sweep bank and checks the synchronized Q bus.
// Optional macro DLT_SWEEP_SR_EN adds an LFSR-driven sr output that feeds every SR input of the bank.

module dlt_sweep_ctrl #(
   parameter int unsigned NUM_VEC   = 64,
   parameter int unsigned SETTLE    = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        d,
   output logic        g,
`ifdef DLT_SWEEP_SR_EN
   output logic        sr,
`endif
   input  logic [31:0] q_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  fail_count,
   output logic [15:0] first_fail_vec,
   output logic [31:0] first_fail_mask
);

   // Latch k = i*2+j; bit k of each mask holds that latch's static parameter.
   localparam logic [31:0] G_INV_M     = 32'hCCCC_CCCC;
   localparam logic [31:0] SR_INV_M    = 32'hF0F0_F0F0;
   localparam logic [31:0] SR_VAL_M    = 32'hFF00_FF00;
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
   localparam logic [15:0] VEC_LAST    = 16'(NUM_VEC - 1);
`ifndef DLT_SWEEP_SR_EN
   localparam logic [31:0] J_M         = 32'hAAAA_AAAA;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_DRV_D, S_WAIT_D, S_DRV_SR, S_WAIT_SR, S_DRV_G, S_WAIT_G, S_CHECK, S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_wait_cnt, r_vec_cnt, r_lfsr;
   logic [31:0] r_q_meta, r_q_sync, r_model, r_known;
   logic        r_d, r_g, r_pass;
   logic [7:0]  r_fail_cnt;
   logic [15:0] r_ffv;
   logic [31:0] r_ffm;

   logic        w_wait_done, w_in_wait, w_model_upd, w_upd_d, w_upd_g, w_any_mis;
   logic [31:0] w_sra, w_open, w_model_nxt, w_known_nxt, w_mismatch;
   logic [7:0]  w_fail_cnt_nxt;

   assign w_wait_done = (r_wait_cnt == SETTLE_LAST);
   assign w_in_wait   = (r_state inside {S_WAIT_D, S_WAIT_SR, S_WAIT_G});
   assign w_model_upd = (r_state inside {S_DRV_D, S_DRV_SR, S_DRV_G});

   // The model sees each net's new value on the same edge that drives it.
   assign w_upd_d = (r_state == S_DRV_D) ? r_lfsr[0] : r_d;
   assign w_upd_g = (r_state == S_DRV_G) ? r_lfsr[1] : r_g;
`ifdef DLT_SWEEP_SR_EN
   logic r_sr, w_upd_sr;
   assign w_upd_sr = (r_state == S_DRV_SR) ? r_lfsr[2] : r_sr;
   assign w_sra    = {32{w_upd_sr}} ^ SR_INV_M;
   assign sr       = r_sr;
`else
   assign w_sra    = J_M ^ SR_INV_M;
`endif
   assign w_open      = {32{w_upd_g}} ^ G_INV_M;
   assign w_model_nxt = (w_sra & SR_VAL_M) | (~w_sra & w_open & {32{w_upd_d}})
                      | (~w_sra & ~w_open & r_model);
   assign w_known_nxt = r_known | w_sra | w_open;

   assign w_mismatch     = (r_q_sync ^ r_model) & r_known;
   assign w_any_mis      = |w_mismatch;
   assign w_fail_cnt_nxt = (w_any_mis && r_fail_cnt != 8'hFF) ? r_fail_cnt + 8'd1 : r_fail_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q_meta <= '0;
         r_q_sync <= '0;
      end else begin
         r_q_meta <= q_in;
         r_q_sync <= r_q_meta;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default first, so no branch leaves the next state unassigned and no latch is inferred.
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: if (start) w_state_nxt = S_DRV_D;
         S_DRV_D:        w_state_nxt = S_WAIT_D;
`ifdef DLT_SWEEP_SR_EN
         S_WAIT_D:       if (w_wait_done) w_state_nxt = S_DRV_SR;
         S_DRV_SR:       w_state_nxt = S_WAIT_SR;
         S_WAIT_SR:      if (w_wait_done) w_state_nxt = S_DRV_G;
`else
         S_WAIT_D:       if (w_wait_done) w_state_nxt = S_DRV_G;
`endif
         S_DRV_G:        w_state_nxt = S_WAIT_G;
         S_WAIT_G:       if (w_wait_done) w_state_nxt = S_CHECK;
         S_CHECK:        w_state_nxt = (r_vec_cnt == VEC_LAST) ? S_DONE : S_DRV_D;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the model and known mask are only 64 flops, so they take the same async clear as the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_vec_cnt  <= '0;
         r_lfsr     <= LFSR_SEED;
         r_model    <= '0;
         r_known    <= '0;
         r_d        <= 1'b0;
         r_g        <= 1'b0;
`ifdef DLT_SWEEP_SR_EN
         r_sr       <= 1'b0;
`endif
         r_pass     <= 1'b0;
         r_fail_cnt <= '0;
         r_ffv      <= 16'hFFFF;
         r_ffm      <= '0;
      end else begin
         r_wait_cnt <= (w_in_wait && !w_wait_done) ? r_wait_cnt + 16'd1 : 16'd0;
         if (w_model_upd) begin
            r_model <= w_model_nxt;
            r_known <= w_known_nxt;
         end
         case (r_state)
            S_IDLE, S_DONE: if (start) begin
               r_lfsr     <= LFSR_SEED;
               r_vec_cnt  <= '0;
               r_fail_cnt <= '0;
               r_known    <= '0;
               r_ffv      <= 16'hFFFF;
               r_ffm      <= '0;
               r_pass     <= 1'b0;
            end
            S_DRV_D:  r_d <= r_lfsr[0];
`ifdef DLT_SWEEP_SR_EN
            S_DRV_SR: r_sr <= r_lfsr[2];
`endif
            S_DRV_G:  r_g <= r_lfsr[1];
            S_CHECK: begin
               r_lfsr     <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
               r_vec_cnt  <= r_vec_cnt + 16'd1;
               r_fail_cnt <= w_fail_cnt_nxt;
               if (w_any_mis && r_ffv == 16'hFFFF) begin
                  r_ffv <= r_vec_cnt;
                  r_ffm <= w_mismatch;
               end
               if (r_vec_cnt == VEC_LAST) r_pass <= (w_fail_cnt_nxt == 8'd0);
            end
            default: ;
         endcase
      end
   end

   assign d               = r_d;
   assign g               = r_g;
   assign busy            = (r_state inside {S_DRV_D, S_WAIT_D, S_DRV_SR, S_WAIT_SR,
                                             S_DRV_G, S_WAIT_G, S_CHECK});
   assign done            = (r_state == S_DONE);
   assign pass            = r_pass;
   assign fail_count      = r_fail_cnt;
   assign first_fail_vec  = r_ffv;
   assign first_fail_mask = r_ffm;

endmodule
